// File: rtl/magnitude_pkg.sv
// Shared types and width helpers for the FFT magnitude scheduler.
package magnitude_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int idx_w(input int buffer_size);
      return (buffer_size > 1) ? $clog2(buffer_size) : 1;
   endfunction

   function automatic int mag_w(input int sample_size);
      return 2 * sample_size;
   endfunction

endpackage

// File: rtl/magnitude_scheduler_if.sv
// Frame-in / magnitude-out handshake bundle; slave is the scheduler side.
interface magnitude_scheduler_if
   import magnitude_pkg::*;
#(
   parameter int SAMPLE_SIZE = 32,
   parameter int BUFFER_SIZE = 32
) ();

   localparam int IW = idx_w(BUFFER_SIZE);
   localparam int MW = mag_w(SAMPLE_SIZE);
   localparam int FW = BUFFER_SIZE * SAMPLE_SIZE;

   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] in_real;
   logic [FW-1:0] in_imag;
   logic          out_valid;
   logic          out_ready;
   logic [MW-1:0] out_mag;
   logic [IW-1:0] out_index;
   logic          out_last;
   logic          peak_valid;
   logic [MW-1:0] peak_mag;
   logic [IW-1:0] peak_index;
   logic          busy;

   modport slave (
      input  in_valid, in_real, in_imag, out_ready,
      output in_ready, out_valid, out_mag, out_index, out_last,
             peak_valid, peak_mag, peak_index, busy
   );

   modport master (
      output in_valid, in_real, in_imag, out_ready,
      input  in_ready, out_valid, out_mag, out_index, out_last,
             peak_valid, peak_mag, peak_index, busy
   );

endinterface

// File: rtl/magnitude_lane.sv
// Two-stage square-and-sum pipeline: stage 1 holds the signed squares,
// stage 2 their unsigned sum. The whole lane moves only when adv_i is high.
module magnitude_lane
   import magnitude_pkg::*;
#(
   parameter int SAMPLE_SIZE = 32,
   parameter int IDX_W       = 5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            adv_i,
   input  logic                            vld_i,
   input  logic signed [SAMPLE_SIZE-1:0]   re_i,
   input  logic signed [SAMPLE_SIZE-1:0]   im_i,
   input  logic [IDX_W-1:0]                idx_i,
   input  logic                            last_i,
   output logic                            vld_o,
   output logic [mag_w(SAMPLE_SIZE)-1:0]   mag_o,
   output logic [IDX_W-1:0]                idx_o,
   output logic                            last_o
);

   localparam int MW = mag_w(SAMPLE_SIZE);

   // A full-width signed square cannot overflow: (-2^(S-1))^2 = 2^(2S-2).
   function automatic logic signed [MW-1:0] square(input logic signed [SAMPLE_SIZE-1:0] x);
      logic signed [MW-1:0] xe;
      xe = {{SAMPLE_SIZE{x[SAMPLE_SIZE-1]}}, x};
      return xe * xe;
   endfunction

   function automatic logic [MW-1:0] mag_sum(input logic signed [MW-1:0] a,
                                             input logic signed [MW-1:0] b);
      return $unsigned(a) + $unsigned(b);
   endfunction

   logic                 vld_p1;
   logic signed [MW-1:0] sq_re_p1;
   logic signed [MW-1:0] sq_im_p1;
   logic [IDX_W-1:0]     idx_p1;
   logic                 last_p1;
   logic                 vld_p2;
   logic [MW-1:0]        mag_p2;
   logic [IDX_W-1:0]     idx_p2;
   logic                 last_p2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         sq_re_p1 <= '0;
         sq_im_p1 <= '0;
         idx_p1   <= '0;
         last_p1  <= 1'b0;
         vld_p2   <= 1'b0;
         mag_p2   <= '0;
         idx_p2   <= '0;
         last_p2  <= 1'b0;
      end else if (adv_i) begin
         // stage 1: squares
         vld_p1   <= vld_i;
         sq_re_p1 <= square(re_i);
         sq_im_p1 <= square(im_i);
         idx_p1   <= idx_i;
         last_p1  <= last_i;
         // stage 2: sum
         vld_p2   <= vld_p1;
         mag_p2   <= mag_sum(sq_re_p1, sq_im_p1);
         idx_p2   <= idx_p1;
         last_p2  <= last_p1;
      end
   end

   assign vld_o  = vld_p2;
   assign mag_o  = mag_p2;
   assign idx_o  = idx_p2;
   assign last_o = last_p2;

endmodule

// File: rtl/magnitude_scheduler.sv
// Latches one FFT frame, streams |X[k]|^2 per bin through the lane and
// reports the frame peak with a one-cycle pulse.
module magnitude_scheduler
   import magnitude_pkg::*;
#(
   parameter int SAMPLE_SIZE = 32,
   parameter int BUFFER_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   magnitude_scheduler_if.slave bus
);

   localparam int IW = idx_w(BUFFER_SIZE);
   localparam int MW = mag_w(SAMPLE_SIZE);
   localparam int FW = BUFFER_SIZE * SAMPLE_SIZE;
   localparam logic [IW-1:0] LAST_IDX = IW'(BUFFER_SIZE - 1);

   state_t                        state_q;
   logic [IW-1:0]                 cnt_q;
   logic [FW-1:0]                 re_q;
   logic [FW-1:0]                 im_q;
   logic [MW-1:0]                 peak_mag_q, peak_mag_d;
   logic [IW-1:0]                 peak_idx_q, peak_idx_d;
   logic                          peak_vld_q;

   logic                          adv;
   logic                          issue;
   logic                          accept;
   logic signed [SAMPLE_SIZE-1:0] re_sel;
   logic signed [SAMPLE_SIZE-1:0] im_sel;
   logic                          lane_vld;
   logic [MW-1:0]                 lane_mag;
   logic [IW-1:0]                 lane_idx;
   logic                          lane_last;

   assign adv    = !lane_vld || bus.out_ready;
   assign issue  = (state_q == RUN) && adv;
   assign accept = lane_vld && bus.out_ready;
   assign re_sel = re_q[int'(cnt_q)*SAMPLE_SIZE +: SAMPLE_SIZE];
   assign im_sel = im_q[int'(cnt_q)*SAMPLE_SIZE +: SAMPLE_SIZE];

   // Strict compare so that ties keep the earliest bin.
   always_comb begin
      peak_mag_d = peak_mag_q;
      peak_idx_d = peak_idx_q;
      if (accept && (lane_mag > peak_mag_q)) begin
         peak_mag_d = lane_mag;
         peak_idx_d = lane_idx;
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == IDLE) && bus.in_valid) begin
         re_q <= bus.in_real;
         im_q <= bus.in_imag;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         peak_mag_q <= '0;
         peak_idx_q <= '0;
         peak_vld_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               peak_vld_q <= 1'b0;
               if (bus.in_valid) begin
                  cnt_q      <= '0;
                  peak_mag_q <= '0;
                  peak_idx_q <= '0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               peak_mag_q <= peak_mag_d;
               peak_idx_q <= peak_idx_d;
               if (adv) begin
                  cnt_q <= cnt_q + IW'(1);
                  if (cnt_q == LAST_IDX) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               peak_mag_q <= peak_mag_d;
               peak_idx_q <= peak_idx_d;
               if (accept && lane_last) begin
                  state_q    <= DONE;
                  peak_vld_q <= 1'b1;
               end
            end
            DONE: begin
               peak_vld_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   magnitude_lane #(
      .SAMPLE_SIZE (SAMPLE_SIZE),
      .IDX_W       (IW)
   ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .adv_i  (adv),
      .vld_i  (issue),
      .re_i   (re_sel),
      .im_i   (im_sel),
      .idx_i  (cnt_q),
      .last_i (cnt_q == LAST_IDX),
      .vld_o  (lane_vld),
      .mag_o  (lane_mag),
      .idx_o  (lane_idx),
      .last_o (lane_last)
   );

   assign bus.in_ready   = (state_q == IDLE);
   assign bus.busy       = (state_q != IDLE);
   assign bus.out_valid  = lane_vld;
   assign bus.out_mag    = lane_mag;
   assign bus.out_index  = lane_idx;
   assign bus.out_last   = lane_last;
   assign bus.peak_valid = peak_vld_q;
   assign bus.peak_mag   = peak_mag_q;
   assign bus.peak_index = peak_idx_q;

endmodule

// File: tb/tb_magnitude_scheduler.sv
// Directed and randomized frames for magnitude_scheduler, checked against
// a per-frame arithmetic model of |X[k]|^2 and the frame peak.
module tb_magnitude_scheduler;
   import magnitude_pkg::*;

   localparam int SS = 16;
   localparam int BS = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   magnitude_scheduler_if #(.SAMPLE_SIZE(SS), .BUFFER_SIZE(BS)) bus ();

   magnitude_scheduler #(.SAMPLE_SIZE(SS), .BUFFER_SIZE(BS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int     fr_re[BS];
   int     fr_im[BS];
   int     alt_re[BS];
   int     alt_im[BS];
   longint exp_mag[BS];
   longint exp_peak;
   int     exp_pidx;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int rand16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   function automatic void build_model();
      exp_peak = 0;
      exp_pidx = 0;
      for (int k = 0; k < BS; k++) begin
         exp_mag[k] = longint'(fr_re[k]) * fr_re[k] + longint'(fr_im[k]) * fr_im[k];
         if (exp_mag[k] > exp_peak) begin
            exp_peak = exp_mag[k];
            exp_pidx = k;
         end
      end
   endfunction

   task automatic load_bus(input bit use_alt);
      for (int k = 0; k < BS; k++) begin
         bus.in_real[k*SS +: SS] = 16'(use_alt ? alt_re[k] : fr_re[k]);
         bus.in_imag[k*SS +: SS] = 16'(use_alt ? alt_im[k] : fr_im[k]);
      end
   endtask

   // mode 0: always ready, 1: ready on alternate cycles, 2: random ready
   task automatic run_frame(input int mode, input bit hold_alt);
      int n, cyc, first_vld;
      bit done, prev_stall;
      logic [31:0] h_mag;
      logic [1:0]  h_idx;
      build_model();
      @(negedge clk);
      load_bus(1'b0);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (hold_alt) load_bus(1'b1);
      else bus.in_valid = 1'b0;
      n = 0; cyc = 0; first_vld = -1; done = 1'b0; prev_stall = 1'b0;
      h_mag = '0; h_idx = '0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            check("busy_after_capture", bus.busy, 1);
            check("in_ready_after_capture", bus.in_ready, 0);
         end
         if (prev_stall) begin
            check("stall_valid_held", bus.out_valid, 1);
            check("stall_mag_held", bus.out_mag, h_mag);
            check("stall_idx_held", bus.out_index, h_idx);
         end
         if (bus.out_valid && first_vld < 0) first_vld = cyc;
         if (bus.peak_valid) begin
            check("peak_after_all_beats", n, BS);
            check("peak_mag", bus.peak_mag, exp_peak);
            check("peak_index", bus.peak_index, exp_pidx);
            done = 1'b1;
         end
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 2) == 1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         prev_stall = bus.out_valid && !bus.out_ready;
         h_mag = bus.out_mag;
         h_idx = bus.out_index;
         if (bus.out_valid && bus.out_ready) begin
            if (n < BS) begin
               check("beat_mag", bus.out_mag, exp_mag[n]);
               check("beat_index", bus.out_index, n);
               check("beat_last", bus.out_last, (n == BS - 1));
            end else begin
               check("extra_beat", n, BS - 1);
            end
            n++;
         end
      end
      check("frame_done", done, 1);
      check("first_valid_latency", first_vld, 3);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("peak_valid_one_cycle", bus.peak_valid, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_in_ready", bus.in_ready, 1);
      check("peak_mag_hold", bus.peak_mag, exp_peak);
      check("peak_index_hold", bus.peak_index, exp_pidx);
   endtask

   initial begin
      bit found;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_real   = '0;
      bus.in_imag   = '0;
      #2;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_mag", bus.out_mag, 0);
      check("rst_out_index", bus.out_index, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_peak_valid", bus.peak_valid, 0);
      check("rst_peak_mag", bus.peak_mag, 0);
      check("rst_peak_index", bus.peak_index, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // basic frame
      fr_re = '{1, 2, 3, 4};
      fr_im = '{0, -1, 2, -3};
      run_frame(0, 1'b0);

      // same frame under alternate-cycle backpressure
      run_frame(1, 1'b0);

      // extreme negative samples, all bins tie
      fr_re = '{-32768, -32768, -32768, -32768};
      fr_im = '{-32768, -32768, -32768, -32768};
      run_frame(2, 1'b0);

      // second frame held on the bus during the first must be ignored
      fr_re  = '{5, -6, 7, 1};
      fr_im  = '{2, 3, -4, 0};
      alt_re = '{100, 200, -300, 9};
      alt_im = '{-1, 0, 50, 400};
      run_frame(0, 1'b1);
      fr_re = alt_re;
      fr_im = alt_im;
      run_frame(0, 1'b0);

      // randomized frames with random backpressure
      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < BS; k++) begin
            fr_re[k] = rand16();
            fr_im[k] = rand16();
         end
         run_frame(2, 1'b0);
      end

      // reset in the middle of a frame
      fr_re = '{1, 2, 3, 4};
      fr_im = '{0, -1, 2, -3};
      @(negedge clk);
      load_bus(1'b0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (bus.out_valid && bus.out_index == 2'd1) found = 1'b1;
      end
      check("mid_reset_bin1_seen", found, 1);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("mid_reset_out_valid", bus.out_valid, 0);
      check("mid_reset_busy", bus.busy, 0);
      check("mid_reset_in_ready", bus.in_ready, 1);
      check("mid_reset_peak_valid", bus.peak_valid, 0);
      check("mid_reset_peak_mag", bus.peak_mag, 0);
      check("mid_reset_out_mag", bus.out_mag, 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("in_reset_no_peak", bus.peak_valid, 0);
         check("in_reset_no_beat", bus.out_valid, 0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      fr_re = '{0, 0, 0, 7};
      fr_im = '{0, 0, 0, 0};
      run_frame(0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
